// File: rtl/cpu_machine_ctl.sv
// Instruction-cycle sequencer: turns the clock generator's fetch/alu_ena phases
// into the eight-cycle control-strobe frame for PC, IR, accumulator, bus and memory.
module cpu_machine_ctl #(
    parameter bit SYNC_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch,
    input  logic       alu_ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       inc_pc,
    output logic       load_acc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       datactl_ena,
    output logic       halt,
    output logic       sync_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    state_t     state_reg;
    state_t     state_next;
    logic       fetch_d;
    logic [2:0] op_q;
    logic       skip_q;
    logic       rise;
    logic       alu_class;

    assign rise      = fetch & ~fetch_d;
    assign alu_class = (op_q == OP_ADD) || (op_q == OP_AND) ||
                       (op_q == OP_XOR) || (op_q == OP_LDA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            fetch_d   <= 1'b0;
            op_q      <= 3'b000;
            skip_q    <= 1'b0;
        end else begin
            state_reg <= state_next;
            fetch_d   <= fetch;
            if (state_reg == S_T2) op_q   <= opcode;
            if (state_reg == S_T4) skip_q <= zero;
        end
    end

    // Halt entry outranks a resync rise; a rise outranks the normal advance.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (rise) state_next = S_T0;
            S_HALT: state_next = S_HALT;
            S_T4: begin
                if (op_q == OP_HLT) state_next = S_HALT;
                else if (rise)      state_next = S_T0;
                else                state_next = S_T5;
            end
            S_T0: state_next = rise ? S_T0 : S_T1;
            S_T1: state_next = rise ? S_T0 : S_T2;
            S_T2: state_next = rise ? S_T0 : S_T3;
            S_T3: state_next = rise ? S_T0 : S_T4;
            S_T5: state_next = rise ? S_T0 : S_T6;
            S_T6: state_next = rise ? S_T0 : S_T7;
            S_T7: state_next = S_T0;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        inc_pc      = 1'b0;
        load_acc    = 1'b0;
        load_pc     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        load_ir     = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;
        case (state_reg)
            S_T0, S_T1: begin
                rd      = 1'b1;
                load_ir = 1'b1;
                inc_pc  = 1'b1;
            end
            S_T4: begin
                rd   = alu_class;
                halt = (op_q == OP_HLT);
            end
            S_T5: begin
                rd          = alu_class;
                load_acc    = alu_class;
                inc_pc      = (op_q == OP_SKZ) && skip_q;
                load_pc     = (op_q == OP_JMP);
                datactl_ena = (op_q == OP_STO);
            end
            S_T6: begin
                wr          = (op_q == OP_STO);
                datactl_ena = (op_q == OP_STO);
            end
            // Second increment steps over the two-byte instruction being skipped.
            S_T7:   inc_pc = (op_q == OP_SKZ) && skip_q;
            S_HALT: halt   = 1'b1;
            default: ;
        endcase
    end

    generate
        if (SYNC_CHECK) begin : g_sync
            logic sync_err_reg;
            logic sync_hit;

            always_comb begin
                sync_hit = 1'b0;
                if (alu_ena && !(state_reg inside {S_T4, S_IDLE, S_HALT}))
                    sync_hit = 1'b1;
                if (rise && (state_reg inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6}))
                    sync_hit = 1'b1;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sync_err_reg <= 1'b0;
                else        sync_err_reg <= sync_err_reg | sync_hit;
            end

            assign sync_err = sync_err_reg;
        end else begin : g_nosync
            assign sync_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_cpu_machine_ctl.sv
// Directed bench for cpu_machine_ctl: drives an aligned fetch/alu_ena generator,
// compares every cycle against a frame-position model, and pins key frames by hand.
module tb_cpu_machine_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch;
    logic       alu_ena;
    logic [2:0] opcode;
    logic       zero;
    logic       inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, sync_err;

    int checks = 0;
    int errors = 0;
    int phase;
    bit glitch;

    logic [7:0] dut_v;
    logic [7:0] fr [8];

    // Bit order: halt, datactl_ena, load_ir, wr, rd, load_pc, load_acc, inc_pc
    assign dut_v = {halt, datactl_ena, load_ir, wr, rd, load_pc, load_acc, inc_pc};

    cpu_machine_ctl #(.SYNC_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .fetch(fetch), .alu_ena(alu_ena),
        .opcode(opcode), .zero(zero),
        .inc_pc(inc_pc), .load_acc(load_acc), .load_pc(load_pc), .rd(rd), .wr(wr),
        .load_ir(load_ir), .datactl_ena(datactl_ena), .halt(halt), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Generator: phase 0 is the fetch rise, fetch high phases 0..3, alu_ena at phase 5.
    task automatic tick();
        @(posedge clk);
        #1;
        phase   = (phase + 1) % 8;
        fetch   = (phase < 4);
        alu_ena = (phase == 5);
        if (glitch && phase == 3) fetch = 1'b0;
        if (glitch && phase == 4) fetch = 1'b1;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 8 && phase != p; i++) tick();
    endtask

    function automatic logic [7:0] col(input int b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = fr[i][b];
        return r;
    endfunction

    // Caller guarantees the DUT sits in T0 (phase 1).
    task automatic frame(input logic [2:0] op, input logic z);
        opcode = op;
        zero   = z;
        for (int i = 0; i < 8; i++) begin
            fr[i] = dut_v;
            tick();
        end
        $display("frame op=%0d zero=%0d rd=%b wr=%b inc_pc=%b load_acc=%b load_pc=%b dctl=%b halt=%b sync_err=%b",
                 op, z, col(3), col(4), col(0), col(1), col(2), col(6), col(7), sync_err);
    endtask

    // Model: position in the frame (-1 idle), halted flag, latched opcode/zero.
    int         m_pos;
    bit         m_halt;
    logic [2:0] m_op;
    logic       m_skip, m_sync, m_pf;

    function automatic logic [7:0] expect_v(input int pos, input bit h,
                                            input logic [2:0] op, input logic s);
        logic [7:0] v;
        bit alu;
        v   = 8'h00;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        if (h) v[7] = 1'b1;
        else case (pos)
            0, 1: begin v[0] = 1'b1; v[3] = 1'b1; v[5] = 1'b1; end
            4: begin v[3] = alu; v[7] = (op == 3'd0); end
            5: begin
                v[3] = alu; v[1] = alu;
                v[0] = (op == 3'd1) && s;
                v[2] = (op == 3'd7);
                v[6] = (op == 3'd6);
            end
            6: begin v[4] = (op == 3'd6); v[6] = (op == 3'd6); end
            7: v[0] = (op == 3'd1) && s;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pos = -1; m_halt = 0; m_op = 3'd0; m_skip = 0; m_sync = 0; m_pf = 0;
                chk("reset_outputs", {23'd0, dut_v, sync_err}, 32'd0);
            end else begin
                bit r;
                chk("strobes", {24'd0, dut_v}, {24'd0, expect_v(m_pos, m_halt, m_op, m_skip)});
                chk("sync_err", {31'd0, sync_err}, {31'd0, m_sync});
                chk("rd_wr_exclusive", {31'd0, rd & wr}, 32'd0);
                chk("pc_exclusive", {31'd0, load_pc & inc_pc}, 32'd0);
                r = fetch && !m_pf;
                if (!m_halt) begin
                    if (r && m_pos >= 0 && m_pos <= 6) m_sync = 1'b1;
                    if (alu_ena && m_pos != 4 && m_pos != -1) m_sync = 1'b1;
                    if (m_pos == 2) m_op = opcode;
                    if (m_pos == 4) m_skip = zero;
                    if (m_pos == -1) begin
                        if (r) m_pos = 0;
                    end else if (m_pos == 4 && m_op == 3'd0) m_halt = 1'b1;
                    else if (r) m_pos = 0;
                    else m_pos = (m_pos + 1) % 8;
                end
                m_pf = fetch;
            end
        end
    end

    initial begin
        logic [7:0] other_acc;
        logic       halt_acc;
        rst_n = 1'b0; phase = 0; fetch = 1'b1; alu_ena = 1'b0;
        glitch = 1'b0; opcode = 3'd0; zero = 1'b0;

        repeat (12) tick();
        chk("in_reset", {23'd0, dut_v, sync_err}, 32'd0);
        wait_phase(6);
        rst_n = 1'b1;
        wait_phase(0);
        chk("idle_before_rise", {24'd0, dut_v}, 32'h00);
        tick();
        chk("t0_after_rise", {24'd0, dut_v}, 32'h29);

        frame(3'b101, 1'b0);                        // LDA
        chk("lda_rd", {24'd0, col(3)}, 32'h33);
        chk("lda_load_acc", {24'd0, col(1)}, 32'h20);
        chk("lda_load_ir", {24'd0, col(5)}, 32'h03);
        chk("lda_sync", {31'd0, sync_err}, 32'd0);

        frame(3'b001, 1'b1);                        // SKZ taken
        chk("skz1_inc_pc", {24'd0, col(0)}, 32'hA3);
        frame(3'b001, 1'b0);                        // SKZ not taken
        chk("skz0_inc_pc", {24'd0, col(0)}, 32'h03);
        chk("skz0_rd", {24'd0, col(3)}, 32'h03);

        frame(3'b110, 1'b0);                        // STO
        chk("sto_dctl", {24'd0, col(6)}, 32'h60);
        chk("sto_wr", {24'd0, col(4)}, 32'h40);
        frame(3'b111, 1'b0);                        // JMP
        chk("jmp_load_pc", {24'd0, col(2)}, 32'h20);
        chk("jmp_wr", {24'd0, col(4)}, 32'h00);
        frame(3'b010, 1'b0);                        // ADD
        chk("add_load_acc", {24'd0, col(1)}, 32'h20);

        // Extra fetch rise while the DUT is in T3.
        opcode = 3'b011;
        glitch = 1'b1;
        wait_phase(5);
        glitch = 1'b0;
        chk("resync_t0", {24'd0, dut_v}, 32'h29);
        chk("resync_sync_err", {31'd0, sync_err}, 32'd1);
        wait_phase(1);
        frame(3'b100, 1'b0);                        // XOR after realign
        chk("sync_sticky", {31'd0, sync_err}, 32'd1);

        // Reset in T5 of ADD.
        opcode = 3'b010;
        wait_phase(6);
        chk("add_t5_load_acc", {31'd0, load_acc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_load_acc", {31'd0, load_acc}, 32'd0);
        chk("async_sync_err", {31'd0, sync_err}, 32'd0);
        chk("async_all", {24'd0, dut_v}, 32'h00);
        repeat (3) tick();
        wait_phase(6);
        rst_n = 1'b1;
        wait_phase(1);

        frame(3'b000, 1'b0);                        // HLT
        chk("hlt_halt", {24'd0, col(7)}, 32'hF0);
        chk("hlt_rd", {24'd0, col(3)}, 32'h03);
        other_acc = 8'h00;
        halt_acc  = 1'b1;
        for (int i = 0; i < 160; i++) begin
            other_acc = other_acc | (dut_v & 8'h7F);
            halt_acc  = halt_acc & halt;
            tick();
        end
        $display("halt hold: halt_all=%b other_strobes=%b sync_err=%b", halt_acc, other_acc, sync_err);
        chk("halt_hold", {31'd0, halt_acc}, 32'd1);
        chk("halt_quiet", {24'd0, other_acc}, 32'h00);
        chk("halt_sync", {31'd0, sync_err}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("halt_reset", {31'd0, halt}, 32'd0);
        repeat (3) tick();
        wait_phase(6);
        rst_n = 1'b1;
        wait_phase(0);
        tick();
        frame(3'b011, 1'b0);                        // AND
        chk("and_rd", {24'd0, col(3)}, 32'h33);
        frame(3'b001, 1'b1);
        chk("skz1b_inc_pc", {24'd0, col(0)}, 32'hA3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_machine_ctl.md
Name: cpu_machine_ctl

Overview:
- Instruction-cycle sequencer directly downstream of the clock/phase generator.
- Consumes the generator's `clk`, `fetch` and `alu_ena`, the decoded opcode from the instruction register, and the accumulator zero flag.
- Produces the per-cycle control strobes for the PC, instruction register, accumulator, data bus driver and memory in an 8-cycle instruction frame.

Parameters:
- SYNC_CHECK, 1, 1 enables the `sync_err` phase-alignment checker; 0 ties `sync_err` low.

Ports:
- clk  input  1  system clock, the clock generator's `clk` output.
- rst_n  input  1  asynchronous active-low reset.
- fetch  input  1  fetch phase from clock generator; high 4 cycles, low 4 cycles, period 8.
- alu_ena  input  1  ALU enable from clock generator; high 1 cycle per period.
- opcode  input  3  instruction-register opcode field; stable T2..T7.
- zero  input  1  accumulator == 0 flag.
- inc_pc  output  1  increment program counter.
- load_acc  output  1  load accumulator from ALU.
- load_pc  output  1  load PC from instruction address field.
- rd  output  1  memory read.
- wr  output  1  memory write.
- load_ir  output  1  load one instruction byte into the instruction register.
- datactl_ena  output  1  drive accumulator onto data bus.
- halt  output  1  CPU halted.
- sync_err  output  1  sticky phase-misalignment flag.

Behaviour:
- Reset is asynchronous and active-low. While `rst_n` = 0:
  - state = IDLE; `fetch_d`, `op_q`, `skip_q` and `sync_err` are 0.
  - All outputs are 0.
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111. ALU-class = ADD, AND, XOR, LDA.
- States: IDLE, T0..T7, HALT. One state register on `clk`.
- `fetch_d` is `fetch` registered. `rise` = `fetch` & ~`fetch_d` (combinational).
- Transitions:
  - IDLE: stays until `rise`, then → T0.
  - Tn → Tn+1 for n = 0..6.
  - T7 → T0.
  - T4 with `op_q` = HLT → HALT.
  - `rise` in any Tn → T0 next (resync). This has priority over the normal advance, but not over entry to HALT.
  - HALT is terminal until reset; `fetch` and `alu_ena` are ignored there.
- Alignment: with a correct generator, `rise` is seen in T7, so T0 is the second `fetch`-high cycle and T4 coincides with `alu_ena`.
- Latching:
  - `op_q` <= `opcode` at the end of T2.
  - `skip_q` <= `zero` at the end of T4. `skip_q` holds the zero value used by both SKZ increments.
- Outputs are combinational decode of the registered state, `op_q` and `skip_q`; no added latency. Any strobe not listed for a state is 0.
  - IDLE: all outputs 0.
  - T0: `rd`, `load_ir`, `inc_pc` (instruction byte 0).
  - T1: `rd`, `load_ir`, `inc_pc` (instruction byte 1).
  - T2, T3: all outputs 0.
  - T4: ALU-class → `rd`. HLT → `halt`.
  - T5: ALU-class → `rd` + `load_acc`. SKZ & `skip_q` → `inc_pc`. JMP → `load_pc`. STO → `datactl_ena`.
  - T6: STO → `wr` + `datactl_ena`.
  - T7: SKZ & `skip_q` → `inc_pc` (second increment skips the 2-byte instruction).
  - HALT: `halt` = 1; all other strobes 0.
- Strobe exclusivity: `wr` and `rd` are never high together. `load_pc` and `inc_pc` are never high together.
- `sync_err` (SYNC_CHECK = 1):
  - Set when `alu_ena` = 1 in any state other than T4 or IDLE.
  - Set when `rise` occurs in T0..T6.
  - Sticky; cleared only by reset.
- Reset mid-instruction: all strobes drop asynchronously; after release the block restarts from IDLE and waits for the next `rise`.

Test Plan:
- Reset/idle:
  - Stimulus: hold `rst_n` = 0 with `fetch` toggling; release during `fetch` low.
  - Required: all outputs 0; first T0 one cycle after the `fetch` rise; T0/T1 show `rd` = `load_ir` = `inc_pc` = 1.
- LDA (101) with aligned generator:
  - Required: `rd` = 1 in T4..T5; `load_acc` = 1 only in T5, the cycle after `alu_ena`; `sync_err` stays 0.
- SKZ (001):
  - `zero` = 1 at end of T4 → `inc_pc` = 1 in T5 and T7, i.e. 4 `inc_pc` cycles per frame.
  - `zero` = 0 → exactly 2 `inc_pc` cycles (T0, T1).
- STO (110) and JMP (111):
  - STO: `datactl_ena` = 1 in T5..T6; `wr` = 1 only in T6.
  - JMP: `load_pc` = 1 only in T5; no `wr`.
- HLT (000):
  - `halt` = 1 from T4 onward; state HALT; all other strobes 0 for 20+ further `fetch` periods.
  - Reset returns `halt` to 0.
- Resync and reset mid-operation:
  - Inject an extra `fetch` rise during T3 → next state T0 and `sync_err` = 1 (sticky).
  - Assert `rst_n` low during T5 of ADD → `load_acc` drops immediately and `sync_err` clears.
